// File: rtl/nibble_accumulator_if.sv
// nibble_accumulator_if: sample, adder and result signals of nibble_accumulator.
interface nibble_accumulator_if #(
   parameter int HI_W  = 4,
   parameter int CNT_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_data;
   logic              in_last;
   logic [3:0]        adder_a;
   logic [3:0]        adder_b;
   logic [3:0]        adder_sum;
   logic              adder_cout;
   logic              out_valid;
   logic              out_ready;
   logic [HI_W+3:0]   out_total;
   logic [CNT_W-1:0]  out_count;
   logic              out_ovf;
   modport master (
      output in_valid, in_data, in_last, adder_sum, adder_cout, out_ready,
      input  in_ready, adder_a, adder_b, out_valid, out_total, out_count, out_ovf
   );
   modport slave (
      input  in_valid, in_data, in_last, adder_sum, adder_cout, out_ready,
      output in_ready, adder_a, adder_b, out_valid, out_total, out_count, out_ovf
   );
endinterface

// File: rtl/nibble_accumulator.sv
// nibble_accumulator: frames 4-bit samples through an external adder into a wide total and count.
// Define NIBBLE_ACC_SAT_EN to saturate the total at all-ones on overflow instead of wrapping.
module nibble_accumulator #(
   parameter int HI_W  = 4,
   parameter int CNT_W = 8
) (
   input logic clk,
   input logic rst_n,
   nibble_accumulator_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   state_t           r_state, w_next;
   logic [3:0]       r_lo;
   logic [HI_W-1:0]  r_hi;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             w_acc, w_rel;
   logic [HI_W:0]    w_hi_sum;
   assign w_acc    = bus.in_valid && (r_state != DONE);
   assign w_rel    = (r_state == DONE) && bus.out_ready;
   assign w_hi_sum = {1'b0, r_hi} + {{HI_W{1'b0}}, bus.adder_cout};
   assign bus.in_ready  = r_state != DONE;
   assign bus.out_valid = r_state == DONE;
   assign bus.adder_a   = r_lo;
   assign bus.adder_b   = bus.in_data;
   assign bus.out_total = {r_hi, r_lo};
   assign bus.out_count = r_cnt;
   assign bus.out_ovf   = r_ovf;
   always_comb begin
      w_next = r_state;
      w_next = w_rel ? IDLE : w_acc ? (bus.in_last ? DONE : ACCUM) : r_state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   // Release and accept are mutually exclusive: accept needs a state other than DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lo  <= '0;
         r_hi  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_rel) begin
         r_lo  <= '0;
         r_hi  <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_acc) begin
`ifdef NIBBLE_ACC_SAT_EN
         {r_hi, r_lo} <= (r_ovf || w_hi_sum[HI_W]) ? '1 : {w_hi_sum[HI_W-1:0], bus.adder_sum};
`else
         {r_hi, r_lo} <= {w_hi_sum[HI_W-1:0], bus.adder_sum};
`endif
         r_ovf <= r_ovf | w_hi_sum[HI_W];
         r_cnt <= &r_cnt ? r_cnt : r_cnt + 1'b1;
      end
   end
endmodule
